// File: rtl/core_bus_pkg.sv
// Shared types and constants for the 2A03 CPU-bus target side.
// Holds the responder state encoding, the address-region encoding, the
// default address windows, and the byte/address types shared with the core.
package core_bus_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [15:0] addr_t;

    // Responder access sequencing
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_ACC  = 2'd1,
        EXT_WAIT = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // Where an address lands
    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_EXT  = 2'd1,
        REG_OPEN = 2'd2
    } region_t;

    localparam int    DEF_RAM_AW         = 11;
    localparam addr_t DEF_RAM_LIMIT      = 16'h2000;
    localparam addr_t DEF_EXT_BASE       = 16'h8000;
    localparam int    DEF_TIMEOUT_CYCLES = 255;
    localparam int    TMO_W              = 16;

    // RAM window wins over the external window; everything else is open bus.
    function automatic region_t decode_region(input addr_t addr,
                                              input addr_t ram_limit,
                                              input addr_t ext_base);
        region_t r;
        if (addr < ram_limit) begin
            r = REG_RAM;
        end else if (addr >= ext_base) begin
            r = REG_EXT;
        end else begin
            r = REG_OPEN;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-bus and external-memory signal bundle for bus_responder.
// The slave modport is the responder; the master modport is the CPU core
// together with the external memory it talks to.
interface bus_responder_if;
    import core_bus_pkg::*;

    addr_t I_addr;
    byte_t I_wr_data;
    logic  I_rdwr;
    logic  I_phy2;
    byte_t O_rd_data;
    logic  O_ready;
    addr_t O_mem_addr;
    byte_t O_mem_wr_data;
    logic  O_mem_we;
    logic  O_mem_req;
    logic  I_mem_ack;
    byte_t I_mem_rd_data;
    logic  O_timeout;

    modport slave (
        input  I_addr, I_wr_data, I_rdwr, I_phy2, I_mem_ack, I_mem_rd_data,
        output O_rd_data, O_ready, O_mem_addr, O_mem_wr_data, O_mem_we,
               O_mem_req, O_timeout
    );

    modport master (
        output I_addr, I_wr_data, I_rdwr, I_phy2, I_mem_ack, I_mem_rd_data,
        input  O_rd_data, O_ready, O_mem_addr, O_mem_wr_data, O_mem_we,
               O_mem_req, O_timeout
    );
endinterface

// File: rtl/bus_ram_sp.sv
// Synchronous single-port work RAM, 2^AW x 8, registered read.
// A read in the same clock as a write to that address returns the old data.
// Contents are never reset.
module bus_ram_sp #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    // Array write and registered read port
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end
            rdata_q <= mem_r[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Target-side end of the 2A03 CPU bus.
// Serves a zero-wait internal work RAM, bridges the external window through a
// req/ack handshake (holding O_ready low until ack), and answers unmapped
// reads with the open-bus latch.
// Optional: define BUS_RESPONDER_TIMEOUT_EN to abandon unanswered external
// requests after TIMEOUT_CYCLES clocks and raise the sticky O_timeout flag.
module bus_responder
    import core_bus_pkg::*;
#(
    parameter int    RAM_AW         = DEF_RAM_AW,
    parameter addr_t RAM_LIMIT      = DEF_RAM_LIMIT,
    parameter addr_t EXT_BASE       = DEF_EXT_BASE,
    parameter int    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           I_clock,
    input  logic           I_reset,
    bus_responder_if.slave bus
);

    state_t state_q, state_d;
    logic   phy2_q;
    byte_t  rd_data_q, rd_data_d;
    logic   ready_q, ready_d;
    addr_t  mem_addr_q, mem_addr_d;
    byte_t  mem_wr_data_q, mem_wr_data_d;
    logic   mem_we_q, mem_we_d;
    logic   mem_req_q, mem_req_d;
    byte_t  open_bus_q, open_bus_d;
    logic   acc_rd_q, acc_rd_d;
    byte_t  acc_wdata_q, acc_wdata_d;

    logic    rise_s;
    region_t region_s;
    logic    ram_en_s;
    logic    ram_we_s;
    byte_t   ram_rdata_s;

`ifdef BUS_RESPONDER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`else
    wire unused_tmo_s = (TIMEOUT_CYCLES != 0);
`endif

    assign rise_s   = bus.I_phy2 & ~phy2_q;
    assign region_s = decode_region(bus.I_addr, RAM_LIMIT, EXT_BASE);

    bus_ram_sp #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (I_clock),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (bus.I_addr[RAM_AW-1:0]),
        .wdata (bus.I_wr_data),
        .rdata (ram_rdata_s)
    );

    // Next-state, RAM strobes and registered-output next values
    always_comb begin
        state_d       = state_q;
        rd_data_d     = rd_data_q;
        ready_d       = ready_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_we_d      = mem_we_q;
        mem_req_d     = mem_req_q;
        open_bus_d    = open_bus_q;
        acc_rd_d      = acc_rd_q;
        acc_wdata_d   = acc_wdata_q;
        ram_en_s      = 1'b0;
        ram_we_s      = 1'b0;
`ifdef BUS_RESPONDER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    acc_rd_d    = bus.I_rdwr;
                    acc_wdata_d = bus.I_wr_data;
                    case (region_s)
                        REG_RAM: begin
                            ram_en_s = 1'b1;
                            ram_we_s = ~bus.I_rdwr;
                            state_d  = RAM_ACC;
                        end
                        REG_EXT: begin
                            mem_req_d     = 1'b1;
                            ready_d       = 1'b0;
                            mem_addr_d    = bus.I_addr;
                            mem_wr_data_d = bus.I_wr_data;
                            mem_we_d      = ~bus.I_rdwr;
`ifdef BUS_RESPONDER_TIMEOUT_EN
                            tmo_cnt_d     = {TMO_W{1'b0}};
`endif
                            state_d       = EXT_WAIT;
                        end
                        REG_OPEN: begin
                            // Open-bus write is dropped; the latch keeps its value.
                            if (bus.I_rdwr) begin
                                rd_data_d = open_bus_q;
                            end else begin
                                rd_data_d = rd_data_q;
                            end
                            state_d = HOLD;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            RAM_ACC: begin
                // Registered RAM read data is valid in this clock.
                if (acc_rd_q) begin
                    rd_data_d  = ram_rdata_s;
                    open_bus_d = ram_rdata_s;
                end else begin
                    open_bus_d = acc_wdata_q;
                end
                state_d = HOLD;
            end
            EXT_WAIT: begin
                if (bus.I_mem_ack && mem_req_q) begin
                    if (acc_rd_q) begin
                        rd_data_d  = bus.I_mem_rd_data;
                        open_bus_d = bus.I_mem_rd_data;
                    end else begin
                        open_bus_d = mem_wr_data_q;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = HOLD;
                end else begin
`ifdef BUS_RESPONDER_TIMEOUT_EN
                    if (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        if (acc_rd_q) begin
                            rd_data_d = open_bus_q;
                        end else begin
                            rd_data_d = rd_data_q;
                        end
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        ready_d   = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        state_d   = EXT_WAIT;
                    end
`else
                    state_d = EXT_WAIT;
`endif
                end
            end
            HOLD: begin
                // Level test also catches a strobe that dropped while stalled.
                if (!bus.I_phy2) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                ready_d   = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // State, strobe history and registered outputs
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            state_q       <= IDLE;
            phy2_q        <= 1'b0;
            rd_data_q     <= 8'h00;
            ready_q       <= 1'b1;
            mem_addr_q    <= 16'h0000;
            mem_wr_data_q <= 8'h00;
            mem_we_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            open_bus_q    <= 8'h00;
            acc_rd_q      <= 1'b1;
            acc_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            phy2_q        <= bus.I_phy2;
            rd_data_q     <= rd_data_d;
            ready_q       <= ready_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_we_q      <= mem_we_d;
            mem_req_q     <= mem_req_d;
            open_bus_q    <= open_bus_d;
            acc_rd_q      <= acc_rd_d;
            acc_wdata_q   <= acc_wdata_d;
        end
    end

`ifdef BUS_RESPONDER_TIMEOUT_EN
    // External-request watchdog counter and sticky timeout flag
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            tmo_cnt_q <= {TMO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.O_timeout = timeout_q;
`else
    assign bus.O_timeout = 1'b0;
`endif

    assign bus.O_rd_data     = rd_data_q;
    assign bus.O_ready       = ready_q;
    assign bus.O_mem_addr    = mem_addr_q;
    assign bus.O_mem_wr_data = mem_wr_data_q;
    assign bus.O_mem_we      = mem_we_q;
    assign bus.O_mem_req     = mem_req_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder.
module tb_bus_responder;
    import core_bus_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bus_responder_if bus_if ();

    bus_responder #(
        .RAM_AW         (11),
        .RAM_LIMIT      (16'h2000),
        .EXT_BASE       (16'h8000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .I_clock (clk),
        .I_reset (rst),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero-wait RAM or open-bus access: ready high and no external request throughout.
    task automatic cpu_access(input string tag, input logic [15:0] a, input logic rd, input logic [7:0] wd);
        bus_if.I_addr    = a;
        bus_if.I_rdwr    = rd;
        bus_if.I_wr_data = wd;
        bus_if.I_phy2    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, " ready/req hi"}, {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0002);
        end
        bus_if.I_phy2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check({tag, " ready/req lo"}, {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0002);
        end
    endtask

    // External access answered by an ack sampled lat clocks after req appears.
    task automatic ext_access(input string tag, input logic [15:0] a, input logic rd,
                              input logic [7:0] wd, input int lat, input logic [7:0] ackd);
        bus_if.I_addr    = a;
        bus_if.I_rdwr    = rd;
        bus_if.I_wr_data = wd;
        bus_if.I_phy2    = 1'b1;
        tick();
        check({tag, " req/ready"}, {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0001);
        check({tag, " mem_addr"}, bus_if.O_mem_addr, a);
        check({tag, " mem_we"}, {15'd0, bus_if.O_mem_we}, {15'd0, ~rd});
        if (!rd) check({tag, " mem_wr_data"}, {8'd0, bus_if.O_mem_wr_data}, {8'd0, wd});
        for (int i = 0; i < lat - 1; i++) begin
            tick();
            check({tag, " stall"}, {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0001);
        end
        bus_if.I_mem_ack     = 1'b1;
        bus_if.I_mem_rd_data = ackd;
        tick();
        bus_if.I_mem_ack     = 1'b0;
        bus_if.I_mem_rd_data = 8'h00;
        check({tag, " done ready/req/we"},
              {13'd0, bus_if.O_ready, bus_if.O_mem_req, bus_if.O_mem_we}, 16'h0004);
        if (rd) check({tag, " rd_data"}, {8'd0, bus_if.O_rd_data}, {8'd0, ackd});
        bus_if.I_phy2 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus_if.I_addr        = 16'h0000;
        bus_if.I_wr_data     = 8'h00;
        bus_if.I_rdwr        = 1'b1;
        bus_if.I_phy2        = 1'b0;
        bus_if.I_mem_ack     = 1'b0;
        bus_if.I_mem_rd_data = 8'h00;
        tick();
        tick();

        // Reset values
        check("rst ready",       {15'd0, bus_if.O_ready},   16'h0001);
        check("rst rd_data",     {8'd0, bus_if.O_rd_data},  16'h0000);
        check("rst req/we",      {14'd0, bus_if.O_mem_req, bus_if.O_mem_we}, 16'h0000);
        check("rst mem_addr",    bus_if.O_mem_addr,         16'h0000);
        check("rst mem_wr_data", {8'd0, bus_if.O_mem_wr_data}, 16'h0000);
        check("rst timeout",     {15'd0, bus_if.O_timeout}, 16'h0000);
        rst = 1'b0;
        tick();

        // RAM write then mirrored read
        cpu_access("ram wr 0123", 16'h0123, 1'b0, 8'h55);
        cpu_access("ram rd 0923", 16'h0923, 1'b1, 8'h00);
        check("ram mirror rd", {8'd0, bus_if.O_rd_data}, 16'h0055);

        // External read, ack 5 clocks after req
        ext_access("ext rd 8000", 16'h8000, 1'b1, 8'h00, 5, 8'hA9);

        // External write, then open-bus read returns the written byte
        ext_access("ext wr C000", 16'hC000, 1'b0, 8'h3C, 2, 8'h00);
        cpu_access("open rd 4000", 16'h4000, 1'b1, 8'h00);
        check("open after ext wr", {8'd0, bus_if.O_rd_data}, 16'h003C);

        // Reset in the middle of an external wait
        bus_if.I_addr = 16'h9000;
        bus_if.I_rdwr = 1'b1;
        bus_if.I_phy2 = 1'b1;
        tick();
        check("pre-rst req", {15'd0, bus_if.O_mem_req}, 16'h0001);
        rst = 1'b1;
        #1;
        check("mid-rst req/ready", {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0002);
        check("mid-rst rd_data", {8'd0, bus_if.O_rd_data}, 16'h0000);
        bus_if.I_phy2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        cpu_access("post-rst ram rd", 16'h0123, 1'b1, 8'h00);
        check("post-rst ram data", {8'd0, bus_if.O_rd_data}, 16'h0055);

        // Stray ack with nothing pending
        bus_if.I_mem_ack     = 1'b1;
        bus_if.I_mem_rd_data = 8'hEE;
        tick();
        bus_if.I_mem_ack     = 1'b0;
        bus_if.I_mem_rd_data = 8'h00;
        tick();
        check("stray ack rd_data", {8'd0, bus_if.O_rd_data}, 16'h0055);
        check("stray ack req/ready", {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0002);

        // Window edges and mirroring at the top of RAM
        cpu_access("ram wr 07FF", 16'h07FF, 1'b0, 8'hA7);
        cpu_access("ram rd 1FFF", 16'h1FFF, 1'b1, 8'h00);
        check("ram rd 1FFF data", {8'd0, bus_if.O_rd_data}, 16'h00A7);
        cpu_access("ram wr 0000", 16'h0000, 1'b0, 8'h12);
        cpu_access("open rd 2000", 16'h2000, 1'b1, 8'h00);
        check("open rd 2000 data", {8'd0, bus_if.O_rd_data}, 16'h0012);
        cpu_access("open wr 4000", 16'h4000, 1'b0, 8'h99);
        cpu_access("open rd 7FFF", 16'h7FFF, 1'b1, 8'h00);
        check("open rd 7FFF data", {8'd0, bus_if.O_rd_data}, 16'h0012);
        cpu_access("ram rd 0800", 16'h0800, 1'b1, 8'h00);
        check("ram rd 0800 data", {8'd0, bus_if.O_rd_data}, 16'h0012);

`ifdef BUS_RESPONDER_TIMEOUT_EN
        // Unanswered external read is abandoned after 16 clocks
        bus_if.I_addr = 16'hA000;
        bus_if.I_rdwr = 1'b1;
        bus_if.I_phy2 = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo still waiting", {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0001);
        end
        tick();
        check("tmo req/ready", {14'd0, bus_if.O_ready, bus_if.O_mem_req}, 16'h0002);
        check("tmo flag", {15'd0, bus_if.O_timeout}, 16'h0001);
        check("tmo rd_data", {8'd0, bus_if.O_rd_data}, 16'h0012);
        bus_if.I_phy2 = 1'b0;
        tick();
        tick();
        check("tmo sticky", {15'd0, bus_if.O_timeout}, 16'h0001);
`else
        check("timeout tied low", {15'd0, bus_if.O_timeout}, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target-side end of the 2A03 CPU bus. Takes the core's address, write data, read/write strobe and phy2 strobe, and returns read data plus the ready/wait signal.
- Serves a zero-wait internal work RAM directly.
- Bridges accesses to a slower external memory port through a req/ack handshake, stretching the CPU cycle by holding ready low.
- Unmapped reads return open-bus data.

Parameters:
- RAM_AW, 11, internal work RAM address width (2 KiB, mirrored across the RAM window)
- RAM_LIMIT, 16'h2000, internal RAM window is $0000..RAM_LIMIT-1
- EXT_BASE, 16'h8000, external window is EXT_BASE..$FFFF
- TIMEOUT_CYCLES, 255, clocks before an unanswered external request is abandoned (only with the optional feature)

Ports:
- I_clock  in  1  system clock, same clock as the core
- I_reset  in  1  asynchronous reset, active-high
- I_addr  in  16  CPU address
- I_wr_data  in  8  CPU write data
- I_rdwr  in  1  1=read, 0=write
- I_phy2  in  1  CPU phase-2 strobe
- O_rd_data  out  8  read data to CPU
- O_ready  out  1  1=proceed, 0=stall CPU
- O_mem_addr  out  16  external address
- O_mem_wr_data  out  8  external write data
- O_mem_we  out  1  external write enable, qualified by req
- O_mem_req  out  1  external request
- I_mem_ack  in  1  one-clock completion pulse
- I_mem_rd_data  in  8  external read data, valid with ack
- O_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, active-high):
  - O_ready=1; O_rd_data=0; O_mem_req=0; O_mem_we=0; O_mem_addr=0; O_mem_wr_data=0; O_timeout=0.
  - Open-bus latch=0; state=IDLE; phy2_q=0.
  - RAM contents are not reset.
- Strobe detection: phy2_q registers I_phy2 each clock. Rise = I_phy2 & ~phy2_q; fall = ~I_phy2 & phy2_q.
- Address, rdwr and write data are sampled only at rise and held internally for the rest of the access.
- Decode priority: addr < RAM_LIMIT -> RAM. Otherwise addr >= EXT_BASE -> EXT. Otherwise -> OPEN.
- State machine, states IDLE, RAM_ACC, EXT_WAIT, HOLD:
  - IDLE, on rise:
    - RAM read: RAM read at addr[RAM_AW-1:0]; O_rd_data valid the next clock; go RAM_ACC.
    - RAM write: write I_wr_data at that clock; go RAM_ACC.
    - EXT: O_mem_req=1, O_ready=0; O_mem_addr, O_mem_wr_data and O_mem_we=~rdwr latched; go EXT_WAIT.
    - OPEN read: O_rd_data = open-bus latch. OPEN write: ignored. Go HOLD.
  - RAM_ACC: one clock; update open-bus latch with the data moved (read data or write data); go HOLD.
  - EXT_WAIT:
    - O_ready stays 0 and all mem outputs stay stable until I_mem_ack.
    - On ack: read -> O_rd_data = I_mem_rd_data and open-bus latch updated; write -> open-bus latch = write data.
    - Same clock as ack: O_mem_req=0, O_mem_we=0, O_ready=1; go HOLD.
  - HOLD: O_rd_data held; on fall go IDLE.
- Ack while O_mem_req=0 is ignored.
- A rise seen outside IDLE is a protocol error: ignored, state unchanged.
- Latency:
  - RAM and OPEN accesses add zero CPU wait states; O_ready is never deasserted.
  - EXT accesses stall for the ack latency. O_ready returns to 1 in the clock after the ack is registered.
- Rise and fall in the same clock cannot occur; no handling required.
- Reset mid-EXT_WAIT: req dropped immediately (asynchronous), ready=1, pending access discarded.
- Mirroring: RAM address wraps modulo 2^RAM_AW. $0800 aliases $0000 for RAM_AW=11.

Optional Feature:
- Macro BUS_RESPONDER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in EXT_WAIT.
  - After TIMEOUT_CYCLES clocks without ack: req=0, we=0, ready=1; a read returns the open-bus latch; O_timeout set sticky until reset; go HOLD.
  - An ack on the expiry clock wins over timeout.
- Undefined: no counter; O_timeout tied 0; EXT_WAIT waits indefinitely.

Decomposition:
- Package core_bus_pkg:
  - state enum (IDLE, RAM_ACC, EXT_WAIT, HOLD)
  - region enum (REG_RAM, REG_EXT, REG_OPEN)
  - default address-window constants
  - 8/16-bit typedefs shared with the core
- One sub-module, bus_ram_sp: synchronous single-port RAM, 2^RAM_AW x 8, registered read, write-first ignored.

Test Plan:
- Write $55 to $0123 then read $0923 -> O_rd_data=$55; O_ready stays 1 throughout.
- Read $8000 with ack 5 clocks after req -> O_ready low exactly until ack; O_mem_addr=$8000, O_mem_we=0; O_rd_data = I_mem_rd_data ($A9).
- Write $3C to $C000 -> O_mem_we=1, O_mem_wr_data=$3C; then read $4000 (OPEN) -> O_rd_data=$3C, no wait state.
- Assert I_reset during EXT_WAIT -> O_mem_req=0 and O_ready=1 the same clock; after release, first RAM read works.
- Ack pulse with no request pending -> no state change, O_rd_data unchanged.
- With BUS_RESPONDER_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> req dropped after 16 clocks, O_timeout=1, read returns the open-bus latch value.
